r5p_gpio_debounce: RTL and testbench

Input conditioning stage between the board GPIO pads and the SoC `gpio_i` bus, on the Arty wrapper's clock domain.
- Synchronises asynchronous pad inputs.
- Filters bounce and glitches with a shared sample tick and per-bit stability counters.
- Produces per-bit rise/fall pulses for interrupt or edge logic.
- Per-bit bypass gives raw synchronised inputs for fast signals such as UART-like bit-banging.

---
 rtl/r5p_gpio_debounce.sv | 121 ++++++++++++
 tb/tb_r5p_gpio_debounce.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/r5p_gpio_debounce.sv
// rtl/r5p_gpio_debounce.sv - GPIO pad synchroniser, debounce filter and edge pulse generator
module r5p_gpio_debounce #(
    parameter int GW       = 32,
    parameter int SYN      = 2,
    parameter int PRESCALE = 1000,
    parameter int CNT      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [GW-1:0] pad_i,
    input  logic [GW-1:0] cfg_byp,
    output logic [GW-1:0] gpio_i,
    output logic [GW-1:0] rise,
    output logic [GW-1:0] fall
);

    // Prescaler and stability counter widths, never narrower than one bit
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (CNT > 1) ? $clog2(CNT) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT - 1);

    // Synchroniser chain; stage SYN-1 is the metastability-safe copy of the pads
    logic [GW-1:0] sync_q [SYN];
    logic [GW-1:0] sync_d [SYN];
    logic [GW-1:0] sync;

    // Shared sample tick
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;

    // Per-bit stability counters and the filtered level
    logic [CW-1:0] cnt_q [GW];
    logic [CW-1:0] cnt_d [GW];
    logic [GW-1:0] gpio_q;
    logic [GW-1:0] gpio_d;

    // Edge pulses registered alongside the level they describe
    logic [GW-1:0] rise_q;
    logic [GW-1:0] rise_d;
    logic [GW-1:0] fall_q;
    logic [GW-1:0] fall_d;

    // Shift the pads through the synchroniser stages
    always_comb begin
        sync_d[0] = pad_i;
        for (int s = 1; s < SYN; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync = sync_q[SYN-1];

    // Free-running prescaler; with PRESCALE=1 it sits at 0 and tick stays high
    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Per-bit filter: a new level is accepted only after CNT consecutive
    // ticks of disagreement; any agreement, on any clock, restarts the count
    always_comb begin
        gpio_d = gpio_q;
        for (int i = 0; i < GW; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cfg_byp[i]) begin
                gpio_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else if (sync[i] == gpio_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_MAX) begin
                    gpio_d[i] = sync[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Pulses come from the level change itself, so bypass and filter share them
    always_comb begin
        rise_d = ~gpio_q &  gpio_d;
        fall_d =  gpio_q & ~gpio_d;
    end

    // State registers; reset clears everything without producing pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYN; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < GW; i++) begin
                cnt_q[i] <= '0;
            end
            pre_q  <= '0;
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int s = 0; s < SYN; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < GW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pre_q  <= pre_d;
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign gpio_i = gpio_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: tb/tb_r5p_gpio_debounce.sv
// tb/tb_r5p_gpio_debounce.sv - directed self-checking bench for r5p_gpio_debounce
module tb_r5p_gpio_debounce;

    localparam int GW       = 4;
    localparam int SYN      = 2;
    localparam int PRESCALE = 4;
    localparam int CNT      = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [GW-1:0] pad_i;
    logic [GW-1:0] cfg_byp;
    logic [GW-1:0] gpio_i;
    logic [GW-1:0] rise;
    logic [GW-1:0] fall;

    int n_assert = 0;
    int n_fail   = 0;

    r5p_gpio_debounce #(
        .GW(GW), .SYN(SYN), .PRESCALE(PRESCALE), .CNT(CNT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pad_i  (pad_i),
        .cfg_byp(cfg_byp),
        .gpio_i (gpio_i),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  found;
        int  gap;
        int  rise_cnt;

        // 1. reset with all pads high, then acceptance on all bits
        rst     = 1'b1;
        pad_i   = 4'hF;
        cfg_byp = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_rst_gpio", gpio_i, 4'h0);
            check("t1_rst_rise", rise, 4'h0);
            check("t1_rst_fall", fall, 4'h0);
        end
        rst   = 1'b0;
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            step();
            if (gpio_i == 4'hF) begin
                found = 1'b1;
                lat   = n;
                check("t1_rise_all", rise, 4'hF);
                check("t1_no_fall", fall, 4'h0);
            end else begin
                check("t1_early_rise", rise, 4'h0);
            end
        end
        check("t1_found", found, 1);
        check("t1_latency_11_15", (lat >= 11 && lat <= 15), 1);
        step();
        check("t1_rise_one_clock", rise, 4'h0);

        // return all pads low before the glitch test
        pad_i = 4'h0;
        found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            step();
            if (gpio_i == 4'h0) begin
                found = 1'b1;
                check("t1_fall_all", fall, 4'hF);
            end
        end
        check("t1_fall_found", found, 1);
        repeat (5) step();

        // 2. eight-clock glitches on bit 0 at random phase never pass
        for (int r = 0; r < 10; r++) begin
            gap = int'($urandom_range(9, 1));
            for (int k = 0; k < gap; k++) begin
                step();
                check("t2_gap", {gpio_i[0], rise[0], fall[0]}, 3'b000);
            end
            pad_i[0] = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                check("t2_glitch", {gpio_i[0], rise[0], fall[0]}, 3'b000);
            end
            pad_i[0] = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            step();
            check("t2_tail", {gpio_i[0], rise[0], fall[0]}, 3'b000);
        end

        // 3. bounce on bit 1, then settle high
        rise_cnt = 0;
        for (int seg = 0; seg < 10; seg++) begin
            pad_i[1] = (seg % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step();
                if (rise[1]) rise_cnt++;
                check("t3_bounce_gpio", gpio_i[1], 1'b0);
            end
        end
        pad_i[1] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (rise[1]) begin
                rise_cnt++;
                lat = n;
            end
        end
        check("t3_one_rise", rise_cnt, 1);
        check("t3_latency_11_15", (lat >= 11 && lat <= 15), 1);
        check("t3_gpio_high", gpio_i[1], 1'b1);

        // 4. bypass on bit 2 passes a single-clock pulse
        cfg_byp = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_idle", {gpio_i[2], rise[2], fall[2]}, 3'b000);
        end
        pad_i[2] = 1'b1;
        step();
        check("t4_c1", {gpio_i[2], rise[2], fall[2]}, 3'b000);
        pad_i[2] = 1'b0;
        step();
        check("t4_c2", {gpio_i[2], rise[2], fall[2]}, 3'b000);
        step();
        check("t4_c3_rise", {gpio_i[2], rise[2], fall[2]}, 3'b110);
        step();
        check("t4_c4_fall", {gpio_i[2], rise[2], fall[2]}, 3'b001);
        step();
        check("t4_c5", {gpio_i[2], rise[2], fall[2]}, 3'b000);
        cfg_byp = 4'b0000;
        repeat (3) step();

        // 5. reset while bit 3 is part-way through its count
        pad_i[3] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            check("t5_pending", gpio_i[3], 1'b0);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t5_rst_gpio", gpio_i, 4'h0);
            check("t5_rst_fall", fall, 4'h0);
            check("t5_rst_rise", rise, 4'h0);
        end
        rst   = 1'b0;
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            step();
            if (gpio_i == 4'b1010) begin
                found = 1'b1;
                lat   = n;
                check("t5_rise", rise, 4'b1010);
            end
        end
        check("t5_found", found, 1);
        check("t5_latency_11_15", (lat >= 11 && lat <= 15), 1);
        repeat (2) step();

        // 6. opposite changes on bits 0 and 3 in the same clock
        pad_i = 4'b0011;
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            step();
            check("t6_bits21", {gpio_i[2:1], rise[2:1], fall[2:1]}, 6'b01_00_00);
            if (rise[0] || fall[3]) begin
                found = 1'b1;
                lat   = n;
                check("t6_rise", rise, 4'b0001);
                check("t6_fall", fall, 4'b1000);
                check("t6_gpio", gpio_i, 4'b0011);
            end
        end
        check("t6_found", found, 1);
        check("t6_latency_11_15", (lat >= 11 && lat <= 15), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
